simt_warp_fetch: RTL
====================

# simt_warp_fetch

Multi-warp instruction fetch and PC unit for the SIMD/SIMT core. It generalises the single-PC fetch logic of the scalar datapath to `NWARPS` independent program counters. Each cycle it selects a ready warp round-robin, fetches its instruction through the load/store unit's instruction port, and hands the instruction to decode. It then blocks that warp until execute commits its next-PC decision (sequential, branch/jump target, or halt). It sits between the load/store unit's instruction side and the per-warp decode/execute logic, and it drives the core-level halt.

## Interface
- `NWARPS`, default 4: number of hardware warps, ≥2.
- `PC_INIT`, default 0: reset PC of warp 0.
- `PC_STRIDE`, default 0: per-warp reset offset; warp w resets to `PC_INIT + w*PC_STRIDE`.
- `WIDX`, default `$clog2(NWARPS)`: warp index width (derived).
- `CLK`, in, 1: clock.
- `nRST`, in, 1: reset, asynchronous, active-low.
- `ireq`, out, 1: instruction fetch request.
- `iaddr`, out, 32: fetch address, the PC of the selected warp.
- `iHit`, in, 1: fetch complete; `iload` is valid this cycle.
- `iload`, in, 32: fetched instruction word.
- `instr_valid`, out, 1: an instruction is offered to decode.
- `instr`, out, 32: offered instruction.
- `instr_warp`, out, WIDX: owning warp of the offered instruction.
- `instr_pc`, out, 32: PC of the offered instruction.
- `issue_ready`, in, 1: decode accepts the offered instruction.
- `commit_en`, in, 1: execute reports next-PC for one warp.
- `commit_warp`, in, WIDX: warp being committed.
- `commit_taken`, in, 1: 1 means load `commit_pc`; 0 means PC+4.
- `commit_pc`, in, 32: branch/jump/JR target.
- `commit_halt`, in, 1: warp executed HALT; it is deactivated.
- `warp_active`, out, NWARPS: per-warp not-halted flags.
- `dhalt`, out, 1: all warps halted, registered.

## Operation
- Per-warp state: `pc[w]` (32b), `active[w]`, `pending[w]`. A warp is ready when `active[w] & ~pending[w]`.
- FSM states: PICK, FETCH, OFFER.
- **PICK:** combinationally finds the first ready warp scanning from `rr+1` (mod NWARPS) upward. If one exists, it registers `sel` and sets `pending[sel]`, then moves to FETCH. Otherwise it stays in PICK.
- **FETCH:** holds `ireq=1` and `iaddr=pc[sel]`. On `iHit` it latches `iload` into the instruction register and `pc[sel]` into `instr_pc`, then moves to OFFER. `ireq` drops in the cycle after `iHit`.
- **OFFER:** holds `instr_valid=1` with `instr`, `instr_warp=sel` and `instr_pc` stable. On `issue_ready` it sets `rr<=sel` and returns to PICK.
- **Commit:** when `commit_en` is high and `pending[commit_warp]` is set:
  - `pending` is cleared.
  - `pc` becomes `commit_pc` if `commit_taken`, else `pc+4` (mod 2^32, wraps).
  - If `commit_halt`, `active` is cleared and `pc` is unchanged.
- A commit to a non-pending warp is ignored and leaves state unchanged.
- A commit to warp `sel` while it is still in FETCH or OFFER is legal only after issue. Before issue, the commit is ignored.
- A commit and a PICK in the same cycle on different warps both take effect. PICK uses pre-commit `pending`, so a committing warp becomes eligible the following cycle.
- `dhalt` is registered as `~|active`. Once set, the FSM stays in PICK with `ireq=0`.

## Timing
- Reset values:
  - every `pc[w] = PC_INIT + w*PC_STRIDE`;
  - `active` all ones;
  - `pending`, `ireq`, `instr_valid`, `instr`, `instr_pc`, `instr_warp`, `dhalt` all 0;
  - `rr = NWARPS-1`, so warp 0 is picked first;
  - FSM in PICK.
- Ready warp to `ireq` high: 1 cycle (PICK→FETCH).
- `iHit` to `instr_valid`: 1 cycle.
- Minimum issue interval per fetch unit: 3 cycles (PICK, FETCH with immediate `iHit`, OFFER with immediate `issue_ready`).
- Last halt commit to `dhalt=1`: 1 cycle.
- Asynchronous reset mid-fetch or mid-offer returns all state to reset values immediately. Outstanding hits after reset are ignored because `ireq=0`.

## Test plan
- Reset, NWARPS=4, PC_STRIDE=0x100, `iHit`/`issue_ready` tied 1, commit each issue the next cycle with taken=0 -> fetch order warp 0,1,2,3,0 at `iaddr` 0x000,0x100,0x200,0x300,0x004.
- Warp 1 commits `taken=1`, `commit_pc=0x8000` -> next warp-1 fetch has `iaddr=0x8000` and `instr_pc=0x8000`.
- Hold `iHit` low 5 cycles in FETCH -> `ireq`/`iaddr` stable for 5 cycles, `instr_valid=0`; the instruction from the `iHit` cycle appears on `instr` 1 cycle later.
- Hold `issue_ready` low in OFFER -> `instr`, `instr_warp` and `instr_pc` stable; no new `ireq`. A commit to another warp in that window still updates that warp's PC.
- Halt warps 0–3 one at a time -> `warp_active` 1110, 1100, 1000, 0000. `dhalt` rises 1 cycle after the last halt, and `ireq` stays 0 thereafter.
- Commit to a non-pending warp, and `pc=0xFFFFFFFC` with taken=0 -> the first is ignored (no PC/state change); the second yields next fetch at `iaddr=0x00000000`.

Source files
------------

// File: rtl/simt_warp_fetch.sv
// Multi-warp instruction fetch: round-robin warp pick, instruction fetch, offer to decode,
// and per-warp next-PC/halt bookkeeping driven by execute commits.
module simt_warp_fetch #(
    parameter int unsigned NWARPS    = 4,
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter logic [31:0] PC_STRIDE = 32'h0000_0000,
    parameter int unsigned WIDX      = $clog2(NWARPS)
) (
    input  logic              CLK,
    input  logic              nRST,
    output logic              ireq,
    output logic [31:0]       iaddr,
    input  logic              iHit,
    input  logic [31:0]       iload,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [WIDX-1:0]   instr_warp,
    output logic [31:0]       instr_pc,
    input  logic              issue_ready,
    input  logic              commit_en,
    input  logic [WIDX-1:0]   commit_warp,
    input  logic              commit_taken,
    input  logic [31:0]       commit_pc,
    input  logic              commit_halt,
    output logic [NWARPS-1:0] warp_active,
    output logic              dhalt
);

    typedef enum logic [1:0] {
        S_PICK  = 2'd0,
        S_FETCH = 2'd1,
        S_OFFER = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [31:0]       pc [NWARPS];
    logic [NWARPS-1:0] active;
    logic [NWARPS-1:0] pending;
    logic [NWARPS-1:0] active_next;
    logic [NWARPS-1:0] pending_next;
    logic [NWARPS-1:0] ready;
    logic [WIDX-1:0]   rr;
    logic [WIDX-1:0]   sel;

    logic              pick_found;
    logic [WIDX-1:0]   pick_idx;
    logic [WIDX-1:0]   cand;
    logic              pick_en;
    logic              fetch_done;
    logic              issue;
    logic              commit_hit;

    assign warp_active = active;
    assign ready       = active & ~pending;

    // Until the in-flight instruction is issued, its own warp cannot be committed.
    assign commit_hit = commit_en && pending[commit_warp]
                        && !((state != S_PICK) && (commit_warp == sel));

    // Round-robin search for the first ready warp after rr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= NWARPS; i++) begin
            cand = WIDX'((32'(rr) + i) % NWARPS);
            if (!pick_found && ready[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_PICK;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pick_en    = 1'b0;
        fetch_done = 1'b0;
        issue      = 1'b0;
        case (state)
            S_PICK: begin
                if (pick_found && !dhalt) begin
                    pick_en    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (iHit) begin
                    fetch_done = 1'b1;
                    state_next = S_OFFER;
                end
            end
            S_OFFER: begin
                if (issue_ready) begin
                    issue      = 1'b1;
                    state_next = S_PICK;
                end
            end
            default: state_next = S_PICK;
        endcase
    end

    // Commit clears pending first; a same-cycle pick only ever targets a non-pending warp.
    always_comb begin
        pending_next = pending;
        active_next  = active;
        if (commit_hit) begin
            pending_next[commit_warp] = 1'b0;
            if (commit_halt) begin
                active_next[commit_warp] = 1'b0;
            end
        end
        if (pick_en) begin
            pending_next[pick_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned w = 0; w < NWARPS; w++) begin
                pc[WIDX'(w)] <= PC_INIT + 32'(w) * PC_STRIDE;
            end
            active      <= '1;
            pending     <= '0;
            rr          <= WIDX'(NWARPS - 1);
            sel         <= '0;
            ireq        <= 1'b0;
            iaddr       <= 32'h0;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_warp  <= '0;
            dhalt       <= 1'b0;
        end else begin
            active      <= active_next;
            pending     <= pending_next;
            dhalt       <= ~|active_next;
            ireq        <= (state_next == S_FETCH);
            instr_valid <= (state_next == S_OFFER);
            if (pick_en) begin
                sel   <= pick_idx;
                iaddr <= pc[pick_idx];
            end
            if (fetch_done) begin
                instr      <= iload;
                instr_pc   <= pc[sel];
                instr_warp <= sel;
            end
            if (issue) begin
                rr <= sel;
            end
            if (commit_hit && !commit_halt) begin
                pc[commit_warp] <= commit_taken ? commit_pc : pc[commit_warp] + 32'd4;
            end
        end
    end

endmodule
